lsu_sq: RTL and testbench

- Store queue that sits on the receiving end of the LSU decode/AGU allocation interface.
- Accepts newly issued stores in program order and holds each one's address, data and width.
- Marks an entry retired when the ROB commits its tag, then drains retired stores in order to the data cache write port.
- On a pipeline flush, discards all stores that have not retired.

---
 rtl/lsu_sq_if.sv | 41 ++++
 rtl/lsu_sq.sv | 133 +++++++++++++
 tb/tb_lsu_sq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sq_if.sv
// Store-queue bus: allocation from decode/AGU, ROB retire, D$ write port.
// master drives requests/acks; slave (the store queue) drives status and D$ writes.
interface lsu_sq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  i_flush;
  logic                  i_alloc_sq_en;
  logic [TAG_WIDTH-1:0]  i_alloc_tag;
  logic [DATA_WIDTH-1:0] i_alloc_data;
  logic [ADDR_WIDTH-1:0] i_alloc_addr;
  logic [3:0]            i_alloc_width;
  logic                  o_full;
  logic                  o_empty;
  logic                  i_rob_retire_en;
  logic [TAG_WIDTH-1:0]  i_rob_retire_tag;
  logic                  o_dc_wr_en;
  logic [ADDR_WIDTH-1:0] o_dc_addr;
  logic [DATA_WIDTH-1:0] o_dc_data;
  logic [3:0]            o_dc_byte_en;
  logic                  i_dc_wr_ack;

  modport master (
    output i_flush, i_alloc_sq_en, i_alloc_tag,
    output i_alloc_data, i_alloc_addr, i_alloc_width,
    output i_rob_retire_en, i_rob_retire_tag,
    output i_dc_wr_ack,
    input  o_full, o_empty, o_dc_wr_en,
    input  o_dc_addr, o_dc_data, o_dc_byte_en
  );

  modport slave (
    input  i_flush, i_alloc_sq_en, i_alloc_tag,
    input  i_alloc_data, i_alloc_addr, i_alloc_width,
    input  i_rob_retire_en, i_rob_retire_tag,
    input  i_dc_wr_ack,
    output o_full, o_empty, o_dc_wr_en,
    output o_dc_addr, o_dc_data, o_dc_byte_en
  );
endinterface

// File: rtl/lsu_sq.sv
// Store queue: holds issued stores in order, retires by ROB tag, drains to D$.
// Ports: clk, n_rst (sync, active-high), sq (lsu_sq_if.slave).
module lsu_sq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int SQ_DEPTH   = 8
) (
  input  logic   clk,
  input  logic   n_rst,
  lsu_sq_if.slave sq
);
  localparam int IW = $clog2(SQ_DEPTH);
  localparam logic [IW:0] ONE = (IW+1)'(1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                state;
  logic [IW:0]           head;
  logic [IW:0]           tail;
  logic [IW-1:0]         hidx;
  logic [IW-1:0]         tidx;
  logic [SQ_DEPTH-1:0]   valid;
  logic [SQ_DEPTH-1:0]   retired;
  logic [SQ_DEPTH-1:0]   hit;
  logic [TAG_WIDTH-1:0]  tag_q   [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [SQ_DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [SQ_DEPTH];
  logic [3:0]            width_q [SQ_DEPTH];
  logic [IW:0]           keep_cnt;
  logic                  full;
  logic                  empty;
  logic [1:0]            sft;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [3:0]            lane_be;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_data;
  logic [3:0]            dc_be;

  assign hidx  = head[IW-1:0];
  assign tidx  = tail[IW-1:0];
  assign full  = (hidx == tidx) && (head[IW] != tail[IW]);
  assign empty = (head == tail);

  assign sq.o_full       = full;
  assign sq.o_empty      = empty;
  assign sq.o_dc_wr_en   = wr_en;
  assign sq.o_dc_addr    = dc_addr;
  assign sq.o_dc_data    = dc_data;
  assign sq.o_dc_byte_en = dc_be;

  // hit: entry retiring this cycle; keep_cnt: entries surviving a flush
  always_comb begin
    hit      = '0;
    keep_cnt = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      hit[i] = sq.i_rob_retire_en && valid[i] && !retired[i] &&
               (tag_q[i] == sq.i_rob_retire_tag);
      if (valid[i] && (retired[i] || hit[i]))
        keep_cnt = keep_cnt + ONE;
    end
  end

  always_comb begin
    sft       = addr_q[hidx][1:0];
    lane_data = data_q[hidx];
    lane_be   = 4'b1111;
    unique case (1'b1)
      width_q[hidx] == 4'd1: begin
        lane_be   = 4'b0001 << sft;
        lane_data = data_q[hidx] << {sft, 3'b000};
      end
      width_q[hidx] == 4'd2: begin
        lane_be   = 4'b0011 << sft;
        lane_data = data_q[hidx] << {sft, 3'b000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state   <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      valid   <= '0;
      retired <= '0;
      wr_en   <= 1'b0;
      dc_addr <= '0;
      dc_data <= '0;
      dc_be   <= '0;
    end else begin
      retired <= retired | hit;

      // Flush first so a same-cycle ack below can still clear its entry
      if (sq.i_flush) begin
        valid <= valid & (retired | hit);
        tail  <= head + keep_cnt;
      end else if (sq.i_alloc_sq_en && !full) begin
        valid[tidx]   <= 1'b1;
        retired[tidx] <= 1'b0;
        tag_q[tidx]   <= sq.i_alloc_tag;
        addr_q[tidx]  <= sq.i_alloc_addr;
        data_q[tidx]  <= sq.i_alloc_data;
        width_q[tidx] <= sq.i_alloc_width;
        tail          <= tail + ONE;
      end

      unique case (state)
        S_IDLE: begin
          if (valid[hidx] && retired[hidx]) begin
            state   <= S_REQ;
            wr_en   <= 1'b1;
            dc_addr <= {addr_q[hidx][ADDR_WIDTH-1:2], 2'b00};
            dc_data <= lane_data;
            dc_be   <= lane_be;
          end
        end
        S_REQ: begin
          if (sq.i_dc_wr_ack) begin
            valid[hidx]   <= 1'b0;
            retired[hidx] <= 1'b0;
            head          <= head + ONE;
            state         <= S_IDLE;
            wr_en         <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_sq.sv
// Self-checking bench for lsu_sq: directed scenarios plus random traffic
// checked against a queue-based model of the store queue.
module tb_lsu_sq;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 6;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  lsu_sq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  lsu_sq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .SQ_DEPTH(D)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .sq(bus)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  w;
    bit          ret;
  } ent_t;

  ent_t q[$];
  bit   m_req;
  int   m_head;
  int   n_tests;
  int   n_fail;
  int   obs[$];

  function automatic logic [3:0] exp_be(logic [31:0] a, logic [3:0] w);
    int s;
    s = int'(a % 4);
    if (w == 1) return 4'((1 << s) & 15);
    if (w == 2) return 4'((3 << s) & 15);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_data(logic [31:0] a, logic [31:0] d,
                                           logic [3:0] w);
    longint unsigned v;
    int s;
    s = int'(a % 4);
    v = d;
    if (w == 1 || w == 2) v = v * (64'd1 << (8 * s));
    return v[31:0];
  endfunction

  task automatic idle();
    bus.i_flush          = 0;
    bus.i_alloc_sq_en    = 0;
    bus.i_alloc_tag      = '0;
    bus.i_alloc_data     = '0;
    bus.i_alloc_addr     = '0;
    bus.i_alloc_width    = '0;
    bus.i_rob_retire_en  = 0;
    bus.i_rob_retire_tag = '0;
    bus.i_dc_wr_ack      = 0;
  endtask

  task automatic alloc(int t, logic [31:0] a, logic [31:0] d, int w);
    bus.i_alloc_sq_en = 1;
    bus.i_alloc_tag   = 6'(t);
    bus.i_alloc_addr  = a;
    bus.i_alloc_data  = d;
    bus.i_alloc_width = 4'(w);
  endtask

  task automatic retire(int t);
    bus.i_rob_retire_en  = 1;
    bus.i_rob_retire_tag = 6'(t);
  endtask

  // One clock: model follows the inputs applied this cycle.
  task automatic tick();
    bit   full0;
    bit   go;
    bit   done;
    ent_t e;
    ent_t k[$];
    @(posedge clk);
    if (n_rst) begin
      q.delete();
      m_req  = 0;
      m_head = 0;
    end else begin
      full0 = (q.size() == D);
      go    = !m_req && q.size() > 0 && q[0].ret;
      done  = 0;
      if (bus.i_rob_retire_en)
        for (int i = 0; i < q.size(); i++)
          if (!done && !q[i].ret && q[i].tag == bus.i_rob_retire_tag) begin
            q[i].ret = 1;
            done = 1;
          end
      if (m_req && bus.i_dc_wr_ack) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % (2 * D);
        m_req  = 0;
      end else if (go) begin
        m_req = 1;
      end
      if (bus.i_flush) begin
        foreach (q[i]) if (q[i].ret) k.push_back(q[i]);
        q = k;
      end else if (bus.i_alloc_sq_en && !full0) begin
        e.tag  = bus.i_alloc_tag;
        e.addr = bus.i_alloc_addr;
        e.data = bus.i_alloc_data;
        e.w    = bus.i_alloc_width;
        e.ret  = 0;
        q.push_back(e);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1;
    tick();
    tick();
    n_rst = 0;
  endtask

  // Ack every request until empty; record addr>>4 of each write.
  task automatic drain(int budget);
    int k;
    obs.delete();
    k = 0;
    while (!bus.o_empty && k < budget) begin
      if (bus.o_dc_wr_en) begin
        obs.push_back(int'(bus.o_dc_addr >> 4));
        n_tests++;
        if (q.size() == 0 ||
            bus.o_dc_byte_en !== exp_be(q[0].addr, q[0].w) ||
            bus.o_dc_data !== exp_data(q[0].addr, q[0].data, q[0].w)) begin
          n_fail++;
          $display("FAIL drain_lane: got be=%h data=%h", bus.o_dc_byte_en,
                   bus.o_dc_data);
        end
        bus.i_dc_wr_ack = 1;
      end
      tick();
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: got not empty want empty");
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({bus.o_empty, bus.o_full, bus.o_dc_wr_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100",
               {bus.o_empty, bus.o_full, bus.o_dc_wr_en});
    end
    n_tests++;
    if ({bus.o_dc_addr, bus.o_dc_data, bus.o_dc_byte_en} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_dc: got %h want 0",
               {bus.o_dc_addr, bus.o_dc_data, bus.o_dc_byte_en});
    end
    n_tests++;
    if ({u_dut.head, u_dut.tail} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ptrs: got %h want 00", {u_dut.head, u_dut.tail});
    end
  endtask

  task automatic test_basic();
    int k;
    do_reset();
    alloc(3, 32'h1002, 32'hABCD, 2);
    tick();
    retire(3);
    tick();
    k = 0;
    while (!bus.o_dc_wr_en && k < 2) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.o_dc_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wr_en: got %b want 1", bus.o_dc_wr_en);
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (bus.o_dc_addr !== 32'h1000 || bus.o_dc_byte_en !== 4'b1100 ||
          bus.o_dc_data !== 32'hABCD0000 || bus.o_dc_wr_en !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_hold%0d: got a=%h be=%b d=%h want 1000 1100 abcd0000",
                 c, bus.o_dc_addr, bus.o_dc_byte_en, bus.o_dc_data);
      end
      if (c < 5) tick();
    end
    bus.i_dc_wr_ack = 1;
    tick();
    n_tests++;
    if (bus.o_empty !== 1'b1 || bus.o_dc_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack: got empty=%b wr=%b want 1 0",
               bus.o_empty, bus.o_dc_wr_en);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int t = 0; t < 8; t++) begin
      alloc(t, 32'(t * 16 + t % 4), $urandom, (t % 3 == 0) ? 1 :
            (t % 3 == 1) ? 2 : 4);
      tick();
    end
    n_tests++;
    if (bus.o_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flag: got %b want 1", bus.o_full);
    end
    alloc(8, 32'h80, 32'h1, 4);
    tick();
    n_tests++;
    if (bus.o_full !== 1'b1 || u_dut.tail !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_drop: got full=%b tail=%h want 1 8",
               bus.o_full, u_dut.tail);
    end
    for (int t = 0; t < 8; t++) begin
      retire(t);
      tick();
    end
    drain(60);
    n_tests++;
    if (obs.size() != 8) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 8", obs.size());
    end
    foreach (obs[i]) begin
      n_tests++;
      if (obs[i] != i) begin
        n_fail++;
        $display("FAIL full_order: got %0d want %0d", obs[i], i);
      end
    end
    n_tests++;
    if (u_dut.head !== 4'b1000 || u_dut.tail !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_wrap: got h=%h t=%h want 8 8",
               u_dut.head, u_dut.tail);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int t = 0; t < 5; t++) begin
      alloc(t, 32'(t * 16), $urandom, 4);
      tick();
    end
    retire(0);
    tick();
    retire(1);
    tick();
    bus.i_flush = 1;
    tick();
    n_tests++;
    if (u_dut.tail !== 4'd2) begin
      n_fail++;
      $display("FAIL flush_tail: got %h want 2", u_dut.tail);
    end
    drain(30);
    n_tests++;
    if (obs.size() != 2 || obs[0] != 0 || obs[1] != 1) begin
      n_fail++;
      $display("FAIL flush_writes: got n=%0d want 2 (tags 0,1)", obs.size());
    end
    alloc(20, 32'h140, 32'h77, 4);
    tick();
    n_tests++;
    if (u_dut.tail !== 4'd3 || u_dut.tag_q[2] !== 6'd20 ||
        u_dut.valid[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_realloc: got tail=%h tag2=%0d want 3 20",
               u_dut.tail, u_dut.tag_q[2]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      alloc(t, 32'(t * 16), $urandom, 4);
      tick();
    end
    retire(0);
    tick();
    retire(1);
    tick();
    bus.i_flush = 1;
    retire(2);
    alloc(9, 32'h90, 32'h99, 4);
    tick();
    drain(30);
    n_tests++;
    if (obs.size() != 3 || obs[0] != 0 || obs[1] != 1 || obs[2] != 2) begin
      n_fail++;
      $display("FAIL same_cycle: got n=%0d want 3 (tags 0,1,2)", obs.size());
    end
  endtask

  task automatic test_misc();
    int k;
    do_reset();
    alloc(5, 32'h7, 32'h5A, 1);
    tick();
    retire(63);
    tick();
    tick();
    n_tests++;
    if (u_dut.retired !== 8'h00 || bus.o_dc_wr_en !== 1'b0 ||
        u_dut.tail !== 4'd1 || u_dut.head !== 4'd0) begin
      n_fail++;
      $display("FAIL unknown_tag: got ret=%h wr=%b want 00 0",
               u_dut.retired, bus.o_dc_wr_en);
    end
    retire(5);
    tick();
    k = 0;
    while (!bus.o_dc_wr_en && k < 3) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.o_dc_wr_en !== 1'b1 || bus.o_dc_addr !== 32'h4 ||
        bus.o_dc_byte_en !== 4'b1000 || bus.o_dc_data !== 32'h5A000000) begin
      n_fail++;
      $display("FAIL byte_lane: got a=%h be=%b d=%h want 4 1000 5a000000",
               bus.o_dc_addr, bus.o_dc_byte_en, bus.o_dc_data);
    end
    bus.i_dc_wr_ack = 1;
    tick();
    n_tests++;
    if (bus.o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_ack: got empty=%b want 1", bus.o_empty);
    end
  endtask

  task automatic test_random();
    int tagc;
    int wsel;
    bit found;
    tagc = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom % 2 == 0) begin
        wsel = $urandom % 4;
        alloc(tagc, $urandom, $urandom,
              (wsel == 0) ? 1 : (wsel == 1) ? 2 : (wsel == 2) ? 4 :
              int'($urandom % 16));
        tagc = (tagc + 1) % 63;
      end
      if ($urandom % 3 == 0) begin
        found = 0;
        foreach (q[i])
          if (!found && !q[i].ret) begin
            retire(int'(q[i].tag));
            found = 1;
          end
      end else if ($urandom % 10 == 0) begin
        retire(63);
      end
      if ($urandom % 25 == 0) bus.i_flush = 1;
      if ($urandom % 2 == 0) bus.i_dc_wr_ack = 1;
      tick();
      n_tests++;
      if (bus.o_empty !== (q.size() == 0) || bus.o_full !== (q.size() == D) ||
          bus.o_dc_wr_en !== m_req) begin
        n_fail++;
        $display("FAIL rnd_flags c%0d: got e=%b f=%b w=%b want n=%0d req=%b",
                 c, bus.o_empty, bus.o_full, bus.o_dc_wr_en, q.size(), m_req);
      end
      n_tests++;
      if (u_dut.head !== 4'(m_head) ||
          u_dut.tail !== 4'((m_head + q.size()) % (2 * D))) begin
        n_fail++;
        $display("FAIL rnd_ptrs c%0d: got h=%h t=%h want h=%0d n=%0d",
                 c, u_dut.head, u_dut.tail, m_head, q.size());
      end
      if (m_req && q.size() > 0) begin
        n_tests++;
        if (bus.o_dc_addr !== (q[0].addr & ~32'h3) ||
            bus.o_dc_byte_en !== exp_be(q[0].addr, q[0].w) ||
            bus.o_dc_data !== exp_data(q[0].addr, q[0].data, q[0].w)) begin
          n_fail++;
          $display("FAIL rnd_lane c%0d: got a=%h be=%b d=%h want a=%h",
                   c, bus.o_dc_addr, bus.o_dc_byte_en, bus.o_dc_data,
                   q[0].addr & ~32'h3);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_rst   = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_same_cycle();
    test_misc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
